// File: rtl/cache_line_arbiter_rr.sv
// Round-robin arbiter multiplexing NUM_PORTS line-granular cache clients onto one downstream line port.
// Optional per-port grant/wait counters are enabled by defining ARB_PERF_CNT_EN.
module cache_line_arbiter_rr #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned s_line    = 256,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          up_read,
    input  logic [NUM_PORTS-1:0]          up_write,
    input  logic [NUM_PORTS*ADDR_W-1:0]   up_address,
    input  logic [NUM_PORTS*s_line-1:0]   up_wdata,
    output logic [s_line-1:0]             up_rdata,
    output logic [NUM_PORTS-1:0]          up_resp,
    output logic                          dn_read,
    output logic                          dn_write,
    output logic [ADDR_W-1:0]             dn_address,
    output logic [s_line-1:0]             dn_wdata,
    input  logic [s_line-1:0]             dn_rdata,
    input  logic                          dn_resp
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [NUM_PORTS*32-1:0]       perf_grants,
    output logic [NUM_PORTS*32-1:0]       perf_wait
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [PORT_W-1:0]    ptr;
    logic [PORT_W-1:0]    ptr_nxt;
    logic [PORT_W-1:0]    grant;
    logic [PORT_W-1:0]    grant_idx;
    logic                 grant_vld;
    logic [NUM_PORTS-1:0] req;
    logic                 sel_write;
    logic [ADDR_W-1:0]    sel_addr;
    logic [s_line-1:0]    sel_wdata;

    // (base + off) mod NUM_PORTS, with both operands already below NUM_PORTS
    function automatic logic [PORT_W-1:0] wrap_add(input logic [PORT_W-1:0] base,
                                                   input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_PORTS) begin
            sum = sum - NUM_PORTS;
        end
        return PORT_W'(sum);
    endfunction

    assign req = up_read | up_write;

    // First requesting port scanning ptr, ptr+1, ... wrapping around
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            if (!grant_vld && req[wrap_add(ptr, k)]) begin
                grant_vld = 1'b1;
                grant_idx = wrap_add(ptr, k);
            end
        end
    end

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (grant_idx == PORT_W'(i)) begin
                sel_write = up_write[i];
                sel_addr  = up_address[i*ADDR_W +: ADDR_W];
                sel_wdata = up_wdata[i*s_line +: s_line];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    state_nxt = BUSY;
                    ptr_nxt   = wrap_add(grant_idx, 1);
                end
            end
            BUSY: begin
                if (dn_resp) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Downstream request is latched at grant; write wins when both op bits are set
    always_ff @(posedge clk) begin
        if (rst) begin
            grant      <= '0;
            dn_read    <= 1'b0;
            dn_write   <= 1'b0;
            dn_address <= '0;
            dn_wdata   <= '0;
            up_rdata   <= '0;
            up_resp    <= '0;
        end else begin
            up_resp <= '0;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        grant      <= grant_idx;
                        dn_write   <= sel_write;
                        dn_read    <= ~sel_write;
                        dn_address <= sel_addr;
                        dn_wdata   <= sel_wdata;
                    end
                end
                BUSY: begin
                    if (dn_resp) begin
                        dn_read  <= 1'b0;
                        dn_write <= 1'b0;
                        up_resp  <= NUM_PORTS'(1) << grant;
                        if (dn_read) begin
                            up_rdata <= dn_rdata;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ARB_PERF_CNT_EN
    localparam int unsigned CNT_W = 32;

    logic [NUM_PORTS-1:0] in_service;

    // A port is in service from the cycle it wins arbitration through its DONE cycle
    always_comb begin
        in_service = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (state != IDLE) begin
                in_service[i] = (grant == PORT_W'(i));
            end else begin
                in_service[i] = grant_vld && (grant_idx == PORT_W'(i));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_grants <= '0;
            perf_wait   <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (state == IDLE && grant_vld && grant_idx == PORT_W'(i)
                    && perf_grants[i*CNT_W +: CNT_W] != 32'hFFFF_FFFF) begin
                    perf_grants[i*CNT_W +: CNT_W] <= perf_grants[i*CNT_W +: CNT_W] + 32'd1;
                end
                if (req[i] && !in_service[i]
                    && perf_wait[i*CNT_W +: CNT_W] != 32'hFFFF_FFFF) begin
                    perf_wait[i*CNT_W +: CNT_W] <= perf_wait[i*CNT_W +: CNT_W] + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_line_arbiter_rr.sv
// Self-checking bench for cache_line_arbiter_rr (4 ports): vector table, corner sequences, random vs model.
module tb_cache_line_arbiter_rr;

    localparam int unsigned NP = 4;
    localparam int unsigned SL = 256;
    localparam int unsigned AW = 32;

    logic              clk;
    logic              rst;
    logic [NP-1:0]     up_read;
    logic [NP-1:0]     up_write;
    logic [NP*AW-1:0]  up_address;
    logic [NP*SL-1:0]  up_wdata;
    logic [SL-1:0]     up_rdata;
    logic [NP-1:0]     up_resp;
    logic              dn_read;
    logic              dn_write;
    logic [AW-1:0]     dn_address;
    logic [SL-1:0]     dn_wdata;
    logic [SL-1:0]     dn_rdata;
    logic              dn_resp;
`ifdef ARB_PERF_CNT_EN
    logic [NP*32-1:0]  perf_grants;
    logic [NP*32-1:0]  perf_wait;
`endif

    logic              p_rd    [NP];
    logic              p_wr    [NP];
    logic [AW-1:0]     p_addr  [NP];
    logic [SL-1:0]     p_wdata [NP];

    int n_cmp;
    int n_err;

    cache_line_arbiter_rr #(.NUM_PORTS(NP), .s_line(SL), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_read    (up_read),
        .up_write   (up_write),
        .up_address (up_address),
        .up_wdata   (up_wdata),
        .up_rdata   (up_rdata),
        .up_resp    (up_resp),
        .dn_read    (dn_read),
        .dn_write   (dn_write),
        .dn_address (dn_address),
        .dn_wdata   (dn_wdata),
        .dn_rdata   (dn_rdata),
        .dn_resp    (dn_resp)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_grants(perf_grants),
        .perf_wait  (perf_wait)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        up_read    = '0;
        up_write   = '0;
        up_address = '0;
        up_wdata   = '0;
        for (int i = 0; i < NP; i++) begin
            up_read[i]             = p_rd[i];
            up_write[i]            = p_wr[i];
            up_address[i*AW +: AW] = p_addr[i];
            up_wdata[i*SL +: SL]   = p_wdata[i];
        end
    end

    typedef struct {
        int            port;
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [SL-1:0] wdata;
        logic [SL-1:0] rdata;
        int            delay;
        logic          exp_read;
        logic          exp_write;
        logic [NP-1:0] exp_resp;
        logic [SL-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [SL-1:0] got, input logic [SL-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [SL-1:0] rand_line();
        logic [SL-1:0] r;
        for (int i = 0; i < SL / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic clear_ports();
        for (int i = 0; i < NP; i++) begin
            p_rd[i]    = 1'b0;
            p_wr[i]    = 1'b0;
            p_addr[i]  = '0;
            p_wdata[i] = '0;
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        dn_resp = 1'b0;
        clear_ports();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_dn_read"},  SL'(dn_read),    '0);
        check({tag, "_dn_write"}, SL'(dn_write),   '0);
        check({tag, "_dn_addr"},  SL'(dn_address), '0);
        check({tag, "_dn_wdata"}, dn_wdata,        '0);
        check({tag, "_up_resp"},  SL'(up_resp),    '0);
        check({tag, "_up_rdata"}, up_rdata,        '0);
    endtask

    // Single transaction from one port; dn_resp is sampled v.delay cycles after dn_* appear
    task automatic run_vec(input vec_t v);
        clear_ports();
        p_rd[v.port]    = v.rd;
        p_wr[v.port]    = v.wr;
        p_addr[v.port]  = v.addr;
        p_wdata[v.port] = v.wdata;
        tick();
        check("vec_dn_read",  SL'(dn_read),    SL'(v.exp_read));
        check("vec_dn_write", SL'(dn_write),   SL'(v.exp_write));
        check("vec_dn_addr",  SL'(dn_address), SL'(v.addr));
        check("vec_dn_wdata", dn_wdata,        v.wdata);
        check("vec_no_early_resp", SL'(up_resp), '0);
        for (int k = 1; k < v.delay; k++) begin
            tick();
            check("vec_busy_hold", SL'({dn_read, dn_write}), SL'({v.exp_read, v.exp_write}));
        end
        dn_rdata = v.rdata;
        dn_resp  = 1'b1;
        tick();
        check("vec_up_resp",  SL'(up_resp), SL'(v.exp_resp));
        check("vec_up_rdata", up_rdata,     v.exp_rdata);
        check("vec_dn_drop",  SL'({dn_read, dn_write}), '0);
        dn_resp  = 1'b0;
        dn_rdata = rand_line();
        clear_ports();
        tick();
        check("vec_resp_one_cycle", SL'(up_resp), '0);
    endtask

    // Random-traffic reference model state
    int            m_ptr;
    bit            m_active;
    bit            m_done;
    bit            m_block;
    int            m_g;
    bit            m_isread;
    int            resp_cnt;
    logic [SL-1:0] m_rdata;
    logic [SL-1:0] m_pend_rdata;
    logic [NP-1:0] prev_req;
    bit            pend [NP];
    int            cool [NP];

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        dn_rdata = '0;
        dn_resp  = 1'b0;
        rst      = 1'b1;
        clear_ports();

        vecs[0] = '{0, 1'b1, 1'b0, 32'h0000_1000, '0, {8{32'hDEADBEEF}}, 4,
                    1'b1, 1'b0, 4'b0001, {8{32'hDEADBEEF}}};
        vecs[1] = '{1, 1'b0, 1'b1, 32'h0000_2020, {8{32'hA5A5A5A5}}, {8{32'h1111_1111}}, 2,
                    1'b0, 1'b1, 4'b0010, {8{32'hDEADBEEF}}};
        vecs[2] = '{0, 1'b1, 1'b1, 32'h0000_3000, {8{32'h0F0F0F0F}}, {8{32'h2222_2222}}, 1,
                    1'b0, 1'b1, 4'b0001, {8{32'hDEADBEEF}}};
        vecs[3] = '{3, 1'b1, 1'b0, 32'h0000_4040, '0, {8{32'h1234_5678}}, 1,
                    1'b1, 1'b0, 4'b1000, {8{32'h1234_5678}}};
        vecs[4] = '{2, 1'b1, 1'b0, 32'h0000_5000, {8{32'h5555_AAAA}}, {4{64'hCAFEF00D_0BADF00D}}, 3,
                    1'b1, 1'b0, 4'b0100, {4{64'hCAFEF00D_0BADF00D}}};

        tick();
        rst = 1'b0;
        check_outputs_zero("reset");

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // All four ports request continuously: grants must rotate 0,1,2,3,0,1
        do_reset();
        for (int i = 0; i < NP; i++) begin
            p_rd[i]   = 1'b1;
            p_addr[i] = 32'h100 * (i + 1);
        end
        for (int n = 0; n < 6; n++) begin
            int w;
            int exp_port;
            exp_port = n % NP;
            w = 0;
            while (!dn_read && w < 10) begin
                tick();
                w++;
            end
            check("rr_grant_seen", SL'(dn_read), SL'(1'b1));
            check("rr_grant_addr", SL'(dn_address), SL'(p_addr[exp_port]));
            dn_resp = 1'b1;
            tick();
            check("rr_up_resp", SL'(up_resp), SL'(4'b0001 << exp_port));
            dn_resp = 1'b0;
            tick();
            check("rr_resp_one_cycle", SL'(up_resp), '0);
        end

        // Reset while BUSY: transaction abandoned, late dn_resp ignored, pointer back to 0
        clear_ports();
        tick();
        p_rd[2]   = 1'b1;
        p_addr[2] = 32'h0000_0700;
        p_addr[0] = 32'h0000_0500;
        tick();
        check("rst_pre_grant", SL'(dn_address), SL'(32'h0000_0700));
        rst     = 1'b1;
        p_rd[2] = 1'b0;
        tick();
        check_outputs_zero("rst_busy");
        rst      = 1'b0;
        dn_resp  = 1'b1;
        dn_rdata = {8{32'h7777_7777}};
        tick();
        check("rst_late_resp",  SL'(up_resp), '0);
        check("rst_late_rdata", up_rdata,     '0);
        dn_resp = 1'b0;
        for (int i = 0; i < NP; i++) p_rd[i] = 1'b1;
        tick();
        check("rst_next_grant", SL'(dn_address), SL'(32'h0000_0500));
        dn_resp = 1'b1;
        clear_ports();
        tick();
        check("rst_next_resp", SL'(up_resp), SL'(4'b0001));
        dn_resp = 1'b0;
        tick();

`ifdef ARB_PERF_CNT_EN
        // Port 1 waits behind port 0 for five cycles
        do_reset();
        p_rd[0]   = 1'b1;
        p_addr[0] = 32'h0000_0A00;
        p_rd[1]   = 1'b1;
        p_addr[1] = 32'h0000_0B00;
        tick();
        tick();
        tick();
        dn_resp = 1'b1;
        tick();
        check("perf_resp0", SL'(up_resp), SL'(4'b0001));
        dn_resp = 1'b0;
        p_rd[0] = 1'b0;
        tick();
        tick();
        check("perf_grant1", SL'(dn_address), SL'(32'h0000_0B00));
        dn_resp = 1'b1;
        tick();
        check("perf_resp1", SL'(up_resp), SL'(4'b0010));
        dn_resp = 1'b0;
        p_rd[1] = 1'b0;
        tick();
        check("perf_grants0", SL'(perf_grants[0 +: 32]),  SL'(32'd1));
        check("perf_grants1", SL'(perf_grants[32 +: 32]), SL'(32'd1));
        check("perf_grants2", SL'(perf_grants[64 +: 32]), SL'(32'd0));
        check("perf_wait0",   SL'(perf_wait[0 +: 32]),    SL'(32'd0));
        check("perf_wait1",   SL'(perf_wait[32 +: 32]),   SL'(32'd5));
`endif

        // Random traffic against a transaction-level model
        do_reset();
        m_ptr    = 0;
        m_active = 0;
        m_done   = 0;
        m_block  = 0;
        m_g      = 0;
        m_isread = 0;
        resp_cnt = 0;
        m_rdata  = '0;
        prev_req = '0;
        for (int i = 0; i < NP; i++) begin
            pend[i] = 0;
            cool[i] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [NP-1:0] exp_resp;
            tick();
            exp_resp = m_done ? (NP'(1) << m_g) : '0;
            check("rnd_up_resp", SL'(up_resp), SL'(exp_resp));
            if (m_done) begin
                if (m_isread) m_rdata = m_pend_rdata;
                check("rnd_done_dn_idle", SL'({dn_read, dn_write}), '0);
                pend[m_g] = 0;
                p_rd[m_g] = 1'b0;
                p_wr[m_g] = 1'b0;
                cool[m_g] = $urandom_range(0, 3);
                m_done  = 0;
                m_block = 1;
            end else if (m_block) begin
                check("rnd_gap_dn_idle", SL'({dn_read, dn_write}), '0);
                m_block = 0;
            end else if (m_active) begin
                check("rnd_busy_hold", SL'({dn_read, dn_write}), SL'({m_isread, !m_isread}));
            end else if (prev_req != '0) begin
                int g;
                g = -1;
                for (int k = 0; k < NP; k++) begin
                    if (g < 0 && prev_req[(m_ptr + k) % NP]) g = (m_ptr + k) % NP;
                end
                m_g      = g;
                m_isread = !p_wr[g];
                check("rnd_grant_op",    SL'({dn_read, dn_write}), SL'({m_isread, !m_isread}));
                check("rnd_grant_addr",  SL'(dn_address), SL'(p_addr[g]));
                check("rnd_grant_wdata", dn_wdata, p_wdata[g]);
                m_ptr    = (g + 1) % NP;
                m_active = 1;
                resp_cnt = $urandom_range(0, 4);
            end else begin
                check("rnd_idle_dn", SL'({dn_read, dn_write}), '0);
            end
            check("rnd_up_rdata", up_rdata, m_rdata);

            dn_resp = 1'b0;
            if (m_active) begin
                if (resp_cnt == 0) begin
                    dn_rdata     = rand_line();
                    dn_resp      = 1'b1;
                    m_pend_rdata = dn_rdata;
                    m_active     = 0;
                    m_done       = 1;
                end else begin
                    resp_cnt--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                dn_rdata = rand_line();
                dn_resp  = 1'b1;
            end

            for (int i = 0; i < NP; i++) begin
                if (!pend[i]) begin
                    if (cool[i] > 0) begin
                        cool[i]--;
                    end else if ($urandom_range(0, 2) == 0) begin
                        int op;
                        op         = $urandom_range(0, 2);
                        pend[i]    = 1;
                        p_rd[i]    = (op != 1);
                        p_wr[i]    = (op != 0);
                        p_addr[i]  = $urandom;
                        p_wdata[i] = rand_line();
                    end
                end
                prev_req[i] = p_rd[i] | p_wr[i];
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
